sccb_byte_engine: RTL and testbench

Write-only SCCB/I2C byte engine for the OV7670 camera's configuration port. It sits directly downstream of the camera init-sequence driver. The driver presents one byte with a strobe and a flag marking the last byte of a register write. This block frames the bytes with START and STOP, serialises them MSB-first on `scl`/`sda`, and reports `busy` until the byte has been shifted out.

---
 rtl/sccb_byte_engine_if.sv | 35 +++
 rtl/sccb_byte_engine.sv | 178 +++++++++++++++++
 tb/tb_sccb_byte_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_byte_engine_if.sv
// sccb_byte_engine_if: byte handshake and SCCB bus signals between the
// camera init-sequence driver (master) and the SCCB byte engine (slave).
// Optional macro SCCB_ACK_CHECK_EN adds sdaIn/ackErr for ninth-bit checking.
interface sccb_byte_engine_if;
    logic       i2cStrobe;
    logic [7:0] dataToSend;
    logic       lastTransfer;
    logic       sda;
    logic       scl;
    logic       busy;
`ifdef SCCB_ACK_CHECK_EN
    logic       sdaIn;
    logic       ackErr;

    modport master (
        output i2cStrobe, dataToSend, lastTransfer, sdaIn,
        input  sda, scl, busy, ackErr
    );

    modport slave (
        input  i2cStrobe, dataToSend, lastTransfer, sdaIn,
        output sda, scl, busy, ackErr
    );
`else
    modport master (
        output i2cStrobe, dataToSend, lastTransfer,
        input  sda, scl, busy
    );

    modport slave (
        input  i2cStrobe, dataToSend, lastTransfer,
        output sda, scl, busy
    );
`endif
endinterface

// File: rtl/sccb_byte_engine.sv
// sccb_byte_engine: write-only SCCB/I2C byte engine for the OV7670 config port.
// Frames bytes with START/STOP, shifts them MSB-first, stays on the bus (HOLD)
// between bytes of one register write. Optional macro SCCB_ACK_CHECK_EN samples
// the ninth bit on sdaIn and reports a sticky ackErr.
module sccb_byte_engine #(
    parameter int QUARTER = 125
) (
    input logic          clk,
    input logic          reset,
    sccb_byte_engine_if.slave bus
);
    localparam int QW = $clog2(QUARTER);
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] BIT   = 3'd2;
    localparam logic [2:0] ACK   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] HOLD  = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [QW-1:0] q_cnt;
    logic [QW-1:0] q_nxt;
    logic [1:0]    phase;
    logic [1:0]    phase_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    data_reg;
    logic          last_reg;
    logic          sda_r;
    logic          scl_r;
    logic          busy_r;
    logic          accept;
    logic          phase_end;

    assign accept    = ((state == IDLE) || (state == HOLD)) && bus.i2cStrobe && !busy_r;
    assign phase_end = (q_cnt == Q_LAST);

    assign bus.sda  = sda_r;
    assign bus.scl  = scl_r;
    assign bus.busy = busy_r;

    // Next state, quarter timer, phase and bit index.
    always_comb begin
        state_nxt = state;
        q_nxt     = q_cnt;
        phase_nxt = phase;
        bit_nxt   = bit_cnt;
        case (state)
            IDLE, HOLD: begin
                q_nxt     = '0;
                phase_nxt = 2'd0;
                if (accept) begin
                    state_nxt = (state == IDLE) ? START : BIT;
                    bit_nxt   = 3'd7;
                end
            end
            default: begin
                if (phase_end) begin
                    q_nxt     = '0;
                    phase_nxt = phase + 2'd1;
                    case (state)
                        START: begin
                            if (phase == 2'd1) begin
                                state_nxt = BIT;
                                phase_nxt = 2'd0;
                            end
                        end
                        BIT: begin
                            if (phase == 2'd3) begin
                                if (bit_cnt == 3'd0) begin
                                    state_nxt = ACK;
                                end else begin
                                    bit_nxt = bit_cnt - 3'd1;
                                end
                            end
                        end
                        ACK: begin
                            if (phase == 2'd3) begin
                                state_nxt = last_reg ? STOP : HOLD;
                            end
                        end
                        STOP: begin
                            if (phase == 2'd3) begin
                                state_nxt = IDLE;
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end else begin
                    q_nxt = q_cnt + 1'b1;
                end
            end
        endcase
    end

    // State registers plus registered bus outputs derived from the upcoming phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            q_cnt    <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            data_reg <= 8'd0;
            last_reg <= 1'b0;
            sda_r    <= 1'b1;
            scl_r    <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            q_cnt   <= q_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_nxt;
            if (accept) begin
                data_reg <= bus.dataToSend;
                last_reg <= bus.lastTransfer;
            end
            busy_r <= (state_nxt != IDLE) && (state_nxt != HOLD);
            case (state_nxt)
                IDLE: begin
                    sda_r <= 1'b1;
                    scl_r <= 1'b1;
                end
                HOLD: begin
                    sda_r <= 1'b0;
                    scl_r <= 1'b0;
                end
                START: begin
                    scl_r <= 1'b1;
                    sda_r <= (phase_nxt == 2'd0);
                end
                BIT, ACK: begin
                    scl_r <= phase_nxt[1];
                    if (phase_nxt == 2'd1) begin
                        sda_r <= (state_nxt == ACK) ? 1'b1 : data_reg[bit_nxt];
                    end
                end
                STOP: begin
                    case (phase_nxt)
                        2'd0: scl_r <= 1'b0;
                        2'd1: begin
                            scl_r <= 1'b0;
                            sda_r <= 1'b0;
                        end
                        2'd2: scl_r <= 1'b1;
                        default: begin
                            scl_r <= 1'b1;
                            sda_r <= 1'b1;
                        end
                    endcase
                end
                default: begin
                    sda_r <= 1'b1;
                    scl_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    logic ack_err_r;

    assign bus.ackErr = ack_err_r;

    // Sticky ninth-bit error: sampled at the end of ACK Q2, cleared when a new START begins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_err_r <= 1'b0;
        end else if ((state_nxt == START) && (state != START)) begin
            ack_err_r <= 1'b0;
        end else if ((state == ACK) && (phase == 2'd2) && phase_end && bus.sdaIn) begin
            ack_err_r <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sccb_byte_engine.sv
// tb_sccb_byte_engine: self-checking bench for sccb_byte_engine (QUARTER=4).
// A frame-level waveform model predicts scl/sda/busy every cycle; a bus monitor
// decodes START/STOP/bits and busy run lengths for literal checks.
module tb_sccb_byte_engine;
    localparam int Q = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    sccb_byte_engine_if bus ();

    sccb_byte_engine #(.QUARTER(Q)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] exp_q[$];
    logic       owned = 1'b0;
    logic       e_scl = 1'b1;
    logic       e_sda = 1'b1;
    logic       e_busy = 1'b0;
    logic       e_ack = 1'b0;
    logic       prev_mark = 1'b0;
    logic       bld_sda = 1'b1;
    logic [2:0] ent;
    bit         model_valid = 1'b0;

    function automatic void push_phase(input logic scl_v, input logic sda_v, input bit hold, input bit mark);
        for (int i = 0; i < Q; i++) begin
            exp_q.push_back({scl_v, hold ? bld_sda : sda_v, mark && (i == Q - 1)});
        end
        if (!hold) bld_sda = sda_v;
    endfunction

    function automatic void build_frame(input logic [7:0] d, input logic from_hold, input logic last);
        if (!from_hold) begin
            push_phase(1'b1, 1'b1, 1'b0, 1'b0);
            push_phase(1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int b = 7; b >= 0; b--) begin
            push_phase(1'b0, 1'b0, 1'b1, 1'b0);
            push_phase(1'b0, d[b], 1'b0, 1'b0);
            push_phase(1'b1, 1'b0, 1'b1, 1'b0);
            push_phase(1'b1, 1'b0, 1'b1, 1'b0);
        end
        push_phase(1'b0, 1'b0, 1'b1, 1'b0);
        push_phase(1'b0, 1'b1, 1'b0, 1'b0);
        push_phase(1'b1, 1'b0, 1'b1, 1'b1);
        push_phase(1'b1, 1'b0, 1'b1, 1'b0);
        if (last) begin
            push_phase(1'b0, 1'b0, 1'b1, 1'b0);
            push_phase(1'b0, 1'b0, 1'b0, 1'b0);
            push_phase(1'b1, 1'b0, 1'b1, 1'b0);
            push_phase(1'b1, 1'b1, 1'b0, 1'b0);
        end
    endfunction

    always @(posedge clk) begin
        model_valid = 1'b1;
        if (!reset) begin
            exp_q.delete();
            owned = 1'b0;
            e_scl = 1'b1;
            e_sda = 1'b1;
            e_busy = 1'b0;
            e_ack = 1'b0;
            prev_mark = 1'b0;
        end else begin
            if (!e_busy && bus.i2cStrobe) begin
                bld_sda = e_sda;
                if (!owned) e_ack = 1'b0;
                build_frame(bus.dataToSend, owned, bus.lastTransfer);
                owned = !bus.lastTransfer;
            end
`ifdef SCCB_ACK_CHECK_EN
            if (prev_mark && bus.sdaIn) e_ack = 1'b1;
`endif
            if (exp_q.size() > 0) begin
                ent = exp_q.pop_front();
                e_scl = ent[2];
                e_sda = ent[1];
                prev_mark = ent[0];
                e_busy = 1'b1;
            end else begin
                e_busy = 1'b0;
                e_scl = !owned;
                e_sda = !owned;
                prev_mark = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check_output("cyc_scl", {31'd0, bus.scl}, {31'd0, e_scl});
            check_output("cyc_sda", {31'd0, bus.sda}, {31'd0, e_sda});
            check_output("cyc_busy", {31'd0, bus.busy}, {31'd0, e_busy});
`ifdef SCCB_ACK_CHECK_EN
            check_output("cyc_ackErr", {31'd0, bus.ackErr}, {31'd0, e_ack});
`endif
        end
    end

    // ---------------- bus monitor ----------------
    int   start_cnt = 0;
    int   stop_cnt = 0;
    int   rise_cnt = 0;
    logic bit_q[$];
    int   hi_q[$];
    int   lo_q[$];
    int   hi_len = 0;
    int   lo_len = 0;
    bit   seen_high = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic m_busy = 1'b0;

    always @(negedge clk) begin
        if (m_scl && bus.scl && m_sda && !bus.sda) start_cnt++;
        if (m_scl && bus.scl && !m_sda && bus.sda) stop_cnt++;
        if (!m_scl && bus.scl && bus.busy) bit_q.push_back(bus.sda);
        if (bus.busy) begin
            if (!m_busy) begin
                rise_cnt++;
                if (seen_high) lo_q.push_back(lo_len);
                hi_len = 0;
            end
            hi_len++;
        end else if (bus.busy == 1'b0) begin
            if (m_busy) begin
                hi_q.push_back(hi_len);
                lo_len = 0;
                seen_high = 1'b1;
            end
            lo_len++;
        end
        m_scl = bus.scl;
        m_sda = bus.sda;
        m_busy = bus.busy;
    end

`ifdef SCCB_ACK_CHECK_EN
    int ack_mode = 2;

    always @(negedge clk) begin
        bus.sdaIn = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : (ack_mode == 1);
    end
`endif

    // ---------------- stimulus ----------------
    int s_bit, s_start, s_stop, s_hi, s_lo, s_rise;

    task automatic snap();
        s_bit = bit_q.size();
        s_start = start_cnt;
        s_stop = stop_cnt;
        s_hi = hi_q.size();
        s_lo = lo_q.size();
        s_rise = rise_cnt;
    endtask

    function automatic logic [7:0] get_byte(input int idx);
        logic [7:0] v = 8'd0;
        for (int i = 0; i < 8; i++) v = {v[6:0], bit_q[idx + i]};
        return v;
    endfunction

    task automatic apply_stimulus(input logic [7:0] d, input logic last, input int hold);
        bus.i2cStrobe = 1'b1;
        bus.dataToSend = d;
        bus.lastTransfer = last;
        repeat (hold) @(negedge clk);
        bus.i2cStrobe = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_done"}, {31'd0, bus.busy}, 32'd0);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] rd;
        logic       rl;
        bus.i2cStrobe = 1'b0;
        bus.dataToSend = 8'd0;
        bus.lastTransfer = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_scl", {31'd0, bus.scl}, 32'd1);
        check_output("reset_sda", {31'd0, bus.sda}, 32'd1);
        check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
`ifdef SCCB_ACK_CHECK_EN
        check_output("reset_ackErr", {31'd0, bus.ackErr}, 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        #1;

        // single byte 0x42 with STOP
        snap();
        apply_stimulus(8'h42, 1'b1, 1);
        wait_idle("single");
        check_output("single_byte", {24'd0, get_byte(s_bit)}, 32'h42);
        check_output("single_ack", {31'd0, bit_q[s_bit + 8]}, 32'd1);
        check_output("single_busy_len", hi_q[s_hi], 32'd168);
        check_output("single_starts", start_cnt - s_start, 32'd1);
        check_output("single_stops", stop_cnt - s_stop, 32'd1);

        // three-byte register write
        snap();
        apply_stimulus(8'h42, 1'b0, 1);
        wait_idle("three_a");
        check_output("hold_scl", {31'd0, bus.scl}, 32'd0);
        apply_stimulus(8'h12, 1'b0, 1);
        wait_idle("three_b");
        check_output("hold_scl2", {31'd0, bus.scl}, 32'd0);
        apply_stimulus(8'h80, 1'b1, 1);
        wait_idle("three_c");
        check_output("three_b0", {24'd0, get_byte(s_bit)}, 32'h42);
        check_output("three_b1", {24'd0, get_byte(s_bit + 9)}, 32'h12);
        check_output("three_b2", {24'd0, get_byte(s_bit + 18)}, 32'h80);
        check_output("three_len0", hi_q[s_hi], 32'd152);
        check_output("three_len1", hi_q[s_hi + 1], 32'd144);
        check_output("three_len2", hi_q[s_hi + 2], 32'd160);
        check_output("three_starts", start_cnt - s_start, 32'd1);
        check_output("three_stops", stop_cnt - s_stop, 32'd1);

        // held strobe
        snap();
        apply_stimulus(8'hA5, 1'b1, 11);
        wait_idle("held");
        check_output("held_rises", rise_cnt - s_rise, 32'd1);
        check_output("held_starts", start_cnt - s_start, 32'd1);
        check_output("held_byte", {24'd0, get_byte(s_bit)}, 32'hA5);
        check_output("held_len", hi_q[s_hi], 32'd168);

        // reset during bit 3
        apply_stimulus(8'h5A, 1'b1, 1);
        repeat (74) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("rstmid_scl", {31'd0, bus.scl}, 32'd1);
        check_output("rstmid_sda", {31'd0, bus.sda}, 32'd1);
        check_output("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        snap();
        apply_stimulus(8'hC3, 1'b1, 1);
        wait_idle("after_rst");
        check_output("after_rst_byte", {24'd0, get_byte(s_bit)}, 32'hC3);
        check_output("after_rst_starts", start_cnt - s_start, 32'd1);
        check_output("after_rst_stops", stop_cnt - s_stop, 32'd1);
        check_output("after_rst_len", hi_q[s_hi], 32'd168);

        // strobe held across busy fall: zero-gap accept from HOLD
        snap();
        bus.i2cStrobe = 1'b1;
        bus.dataToSend = 8'h42;
        bus.lastTransfer = 1'b0;
        @(negedge clk);
        bus.dataToSend = 8'h3C;
        bus.lastTransfer = 1'b1;
        begin
            int n = 0;
            while (bus.busy !== 1'b0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        bus.i2cStrobe = 1'b0;
        wait_idle("zero_gap");
        check_output("zero_gap_low", lo_q[s_lo], 32'd1);
        check_output("zero_gap_len0", hi_q[s_hi], 32'd152);
        check_output("zero_gap_len1", hi_q[s_hi + 1], 32'd160);
        check_output("zero_gap_b0", {24'd0, get_byte(s_bit)}, 32'h42);
        check_output("zero_gap_b1", {24'd0, get_byte(s_bit + 9)}, 32'h3C);
        check_output("zero_gap_starts", start_cnt - s_start, 32'd1);

        // randomized traffic against the model
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            rd = 8'($urandom);
            rl = ($urandom_range(0, 2) == 0) || (t == 29);
            apply_stimulus(rd, rl, $urandom_range(1, 3));
            wait_idle("rand");
        end

`ifdef SCCB_ACK_CHECK_EN
        ack_mode = 1;
        @(negedge clk);
        #1;
        apply_stimulus(8'h11, 1'b0, 1);
        wait_idle("ack_a");
        check_output("ack_err_set", {31'd0, bus.ackErr}, 32'd1);
        repeat (3) @(negedge clk);
        check_output("ack_err_hold", {31'd0, bus.ackErr}, 32'd1);
        ack_mode = 0;
        #1;
        apply_stimulus(8'h22, 1'b1, 1);
        wait_idle("ack_b");
        check_output("ack_err_sticky", {31'd0, bus.ackErr}, 32'd1);
        apply_stimulus(8'h33, 1'b1, 1);
        check_output("ack_err_clear", {31'd0, bus.ackErr}, 32'd0);
        wait_idle("ack_c");
        check_output("ack_err_ok", {31'd0, bus.ackErr}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
